sram_port_arbiter: RTL and testbench

- Shares one single-port SRAM macro (512x45 class, word-addressed, active-low CEB/WEB/BWEB) between the instruction-fetch port and the data-memory port of the CPU.
- Sits between the core and the macro wrapper; allows a unified-memory build of top to replace separate IM/DM instances.
- Data-priority arbitration with a starvation guard for fetch; one-cycle read latency routed back to the granted requester.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/sram_starve_ctr.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified SRAM port arbiter.
package mem_arb_pkg;

  localparam int AW_DEF           = 14;
  localparam int DW_DEF           = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  // Which requester (if any) owns the read data returning this cycle.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_e;

  // Expand active-high byte strobes into the macro's active-low bit mask.
  function automatic logic [31:0] strb2bweb(input logic [3:0] strb);
    logic [31:0] m;
    m = '1;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{~strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_starve_ctr.sv
// Saturating counter of consecutive cycles the fetch port has been denied.
module sram_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic          at_limit,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over increment; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_V);
  assign cnt      = cnt_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the fetch port (read-only) and the
// data port. Data has priority; fetch is forced through after STARVE_LIMIT
// consecutive denials. Read data returns one cycle after the grant and is
// routed to whichever port issued the read.
//
// Handshake: req/addr/data are held by the requester until its gnt is seen
// high; gnt is combinational and means the SRAM access happens this cycle.
// rvalid pulses for one cycle exactly one cycle after a read grant; writes
// complete with their grant and never produce rvalid.
module sram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int SCW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  // fetch port
  input  logic           i_req,
  input  logic [AW-1:0]  i_addr,
  output logic           i_gnt,
  output logic           i_rvalid,
  output logic [DW-1:0]  i_rdata,
  // data port
  input  logic           d_req,
  input  logic           d_we,
  input  logic [AW-1:0]  d_addr,
  input  logic [3:0]     d_wstrb,
  input  logic [DW-1:0]  d_wdata,
  output logic           d_gnt,
  output logic           d_rvalid,
  output logic [DW-1:0]  d_rdata,
  // SRAM macro
  output logic           sram_ceb,
  output logic           sram_web,
  output logic [DW-1:0]  sram_bweb,
  output logic [AW-1:0]  sram_a,
  output logic [DW-1:0]  sram_d,
  input  logic [DW-1:0]  sram_q,
  // debug visibility
  output logic [1:0]     dbg_rsp,
  output logic [SCW-1:0] dbg_starve_cnt
);

  logic           at_limit;
  logic [SCW-1:0] starve_cnt;
  logic           i_win;
  logic           d_win;
  logic           starve_inc;

  rsp_e rsp_q;
  rsp_e rsp_d;
  logic i_rvalid_q;
  logic d_rvalid_q;

  // Arbitration: data first unless fetch has hit the starvation limit.
  // Grants are suppressed while reset is held so the macro stays idle.
  always_comb begin
    i_win = i_req && (!d_req || at_limit);
    d_win = d_req && !i_win;
    i_gnt = rst && i_win;
    d_gnt = rst && d_win;
  end

  assign starve_inc = i_req && !i_gnt;

  sram_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CW    (SCW)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (!starve_inc),
    .at_limit (at_limit),
    .cnt      (starve_cnt)
  );

  // Drive the macro from the winner; idle values when nobody is granted.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (i_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = i_addr;
    end else if (d_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = d_addr;
      sram_d   = d_wdata;
      if (d_we) begin
        sram_web  = 1'b0;
        sram_bweb = DW'(strb2bweb(d_wstrb));
      end
    end
  end

  // Next response owner: whoever issued a read this cycle.
  always_comb begin
    rsp_d = RSP_NONE;
    if (i_gnt) begin
      rsp_d = RSP_I;
    end else if (d_gnt && !d_we) begin
      rsp_d = RSP_D;
    end
  end

  // Response FSM with registered valid outputs; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_q      <= RSP_NONE;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      rsp_q      <= rsp_d;
      i_rvalid_q <= (rsp_d == RSP_I);
      d_rvalid_q <= (rsp_d == RSP_D);
    end
  end

  // Route the macro output to the owning port; the other port sees zero.
  always_comb begin
    i_rdata = '0;
    d_rdata = '0;
    if (rsp_q == RSP_I) begin
      i_rdata = sram_q;
    end
    if (rsp_q == RSP_D) begin
      d_rdata = sram_q;
    end
  end

  assign i_rvalid       = i_rvalid_q;
  assign d_rvalid       = d_rvalid_q;
  assign dbg_rsp        = rsp_q;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM macro
// and a reference memory/arbitration model.
module tb_sram_port_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int SCW = 3;
  localparam int NW  = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           i_req, i_gnt, i_rvalid;
  logic [AW-1:0]  i_addr;
  logic [DW-1:0]  i_rdata;
  logic           d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0]  d_addr;
  logic [3:0]     d_wstrb;
  logic [DW-1:0]  d_wdata, d_rdata;
  logic           sram_ceb, sram_web;
  logic [DW-1:0]  sram_bweb, sram_d, sram_q;
  logic [AW-1:0]  sram_a;
  logic [1:0]     dbg_rsp;
  logic [SCW-1:0] dbg_starve_cnt;

  sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q),
    .dbg_rsp(dbg_rsp), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- SRAM macro model ----------------
  logic [DW-1:0] sram_mem [NW];
  logic [DW-1:0] ref_mem  [NW];
  logic          sram_init_done = 1'b0;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [DW-1:0] pre_d  = '0;

  function automatic logic [DW-1:0] init_pat(input int k);
    return (32'(k) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int k = 0; k < NW; k++) sram_mem[k] = init_pat(k);
      sram_init_done = 1'b1;
    end
    if (pre_en) sram_mem[pre_a] = pre_d;
    if (!sram_ceb) begin
      if (!sram_web) sram_mem[sram_a] = (sram_mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
      else sram_q <= sram_mem[sram_a];
    end
  end

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Apply one cycle of requests just after the edge; return at the
  // following negedge, where the bench samples.
  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                       input logic [AW-1:0] da, input logic [3:0] ds, input logic [DW-1:0] dd);
    @(posedge clk); #1;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wstrb = ds; d_wdata = dd;
    @(negedge clk);
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  // Load a word into both the macro and the reference memory (ports idle).
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(posedge clk); #1;
    pre_a = a; pre_d = v; pre_en = 1'b1;
    ref_mem[a] = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return AW'($urandom_range(1, 7));
      default: return AW'($urandom);
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 14'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0020; d_wstrb = 4'h0; d_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (i_gnt !== 1'b0) begin errors++; $display("FAIL reset_i_gnt got %b exp 0", i_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got %b exp 0", d_gnt); end
    checks++; if (sram_ceb !== 1'b1) begin errors++; $display("FAIL reset_ceb got %b exp 1", sram_ceb); end
    checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b exp 00", i_rvalid, d_rvalid); end
    checks++; if (i_rdata !== '0 || d_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", i_rdata, d_rdata); end
    checks++; if (dbg_starve_cnt !== '0 || dbg_rsp !== 2'd0) begin errors++; $display("FAIL reset_state got cnt %0d rsp %0d exp 0/0", dbg_starve_cnt, dbg_rsp); end
    @(posedge clk); #1;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++; if (sram_ceb !== 1'b1 || i_rvalid !== 1'b0) begin errors++; $display("FAIL reset_release got ceb %b irv %b exp 1/0", sram_ceb, i_rvalid); end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      drive_idle();
      checks++; if (sram_ceb !== 1'b1 || sram_web !== 1'b1) begin errors++; $display("FAIL idle_ce_we got %b%b exp 11", sram_ceb, sram_web); end
      checks++; if (sram_bweb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL idle_bweb got %h exp ffffffff", sram_bweb); end
      checks++; if (sram_a !== '0 || sram_d !== '0) begin errors++; $display("FAIL idle_a_d got %h/%h exp 0", sram_a, sram_d); end
      checks++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0) begin errors++; $display("FAIL idle_hs got %b exp 0000", {i_gnt, d_gnt, i_rvalid, d_rvalid}); end
      checks++; if (dbg_starve_cnt !== '0) begin errors++; $display("FAIL idle_starve got %0d exp 0", dbg_starve_cnt); end
    end
  endtask

  task automatic test_lone_fetch();
    preload(14'h0010, 32'hDEAD_BEEF);
    drive(1'b1, 14'h0010, 1'b0, 1'b0, '0, 4'h0, '0);
    checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got %b%b exp 10", i_gnt, d_gnt); end
    checks++; if (sram_ceb !== 1'b0 || sram_web !== 1'b1) begin errors++; $display("FAIL fetch_ce_we got %b%b exp 01", sram_ceb, sram_web); end
    checks++; if (sram_a !== 14'h0010) begin errors++; $display("FAIL fetch_addr got %h exp 0010", sram_a); end
    drive_idle();
    checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid got %b%b exp 10", i_rvalid, d_rvalid); end
    checks++; if (i_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_rdata got %h exp deadbeef", i_rdata); end
    checks++; if (d_rdata !== '0) begin errors++; $display("FAIL fetch_d_rdata got %h exp 0", d_rdata); end
  endtask

  task automatic test_write_strobe();
    preload(14'h2000, 32'hAAAA_AAAA);
    drive(1'b0, '0, 1'b1, 1'b1, 14'h2000, 4'b0011, 32'h1234_5678);
    checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got %b%b exp 01", i_gnt, d_gnt); end
    checks++; if (sram_ceb !== 1'b0 || sram_web !== 1'b0) begin errors++; $display("FAIL wr_ce_we got %b%b exp 00", sram_ceb, sram_web); end
    checks++; if (sram_bweb !== 32'hFFFF_0000) begin errors++; $display("FAIL wr_bweb got %h exp ffff0000", sram_bweb); end
    checks++; if (sram_d !== 32'h1234_5678 || sram_a !== 14'h2000) begin errors++; $display("FAIL wr_a_d got %h/%h exp 2000/12345678", sram_a, sram_d); end
    drive(1'b0, '0, 1'b1, 1'b0, 14'h2000, 4'h0, '0);
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", d_rvalid); end
    checks++; if (d_gnt !== 1'b1 || sram_web !== 1'b1 || sram_bweb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rd_drive got gnt %b web %b bweb %h", d_gnt, sram_web, sram_bweb); end
    drive_idle();
    checks++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin errors++; $display("FAIL wr_readback_v got %b%b exp 01", i_rvalid, d_rvalid); end
    checks++; if (d_rdata !== 32'hAAAA_5678) begin errors++; $display("FAIL wr_readback got %h exp aaaa5678", d_rdata); end
    ref_mem[14'h2000] = 32'hAAAA_5678;
  endtask

  task automatic test_starvation();
    preload(14'h0100, 32'h1111_0100);
    preload(14'h0200, 32'h2222_0200);
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 14'h0100, 1'b1, 1'b0, 14'h0200, 4'h0, '0);
      checks++; if (i_gnt !== (k % 5 == 4) || d_gnt !== (k % 5 != 4)) begin errors++; $display("FAIL starve_gnt cyc %0d got %b%b", k, i_gnt, d_gnt); end
      checks++; if (dbg_starve_cnt !== SCW'(k % 5)) begin errors++; $display("FAIL starve_cnt cyc %0d got %0d exp %0d", k, dbg_starve_cnt, k % 5); end
      if (k > 0) begin
        checks++; if (i_rvalid !== ((k - 1) % 5 == 4) || d_rvalid !== ((k - 1) % 5 != 4)) begin errors++; $display("FAIL starve_rvalid cyc %0d got %b%b", k, i_rvalid, d_rvalid); end
        checks++; if (i_rdata !== (((k - 1) % 5 == 4) ? 32'h1111_0100 : 32'h0) || d_rdata !== (((k - 1) % 5 != 4) ? 32'h2222_0200 : 32'h0)) begin errors++; $display("FAIL starve_rdata cyc %0d got %h/%h", k, i_rdata, d_rdata); end
      end
    end
    drive_idle();
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h1111_0100) begin errors++; $display("FAIL starve_last got %b/%h exp 1/11110100", i_rvalid, i_rdata); end
  endtask

  task automatic test_back_to_back();
    preload(14'h3FFF, 32'hFFFF_FFFF);
    preload(14'h0000, 32'h0BAD_F00D);
    drive(1'b0, '0, 1'b1, 1'b0, 14'h3FFF, 4'h0, '0);
    checks++; if (d_gnt !== 1'b1 || sram_a !== 14'h3FFF) begin errors++; $display("FAIL b2b_d_gnt got %b/%h exp 1/3fff", d_gnt, sram_a); end
    drive(1'b1, 14'h0000, 1'b0, 1'b0, '0, 4'h0, '0);
    checks++; if (i_gnt !== 1'b1 || sram_ceb !== 1'b0) begin errors++; $display("FAIL b2b_i_gnt got %b/%b exp 1/0", i_gnt, sram_ceb); end
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hFFFF_FFFF || i_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_d_rsp got %b/%h irv %b", d_rvalid, d_rdata, i_rvalid); end
    drive_idle();
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0BAD_F00D || d_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_i_rsp got %b/%h drv %b", i_rvalid, i_rdata, d_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    preload(14'h0055, 32'h600D_CAFE);
    drive(1'b1, 14'h0055, 1'b0, 1'b0, '0, 4'h0, '0);
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", i_gnt); end
    #1 rst = 1'b0;
    #1;
    checks++; if (i_gnt !== 1'b0 || sram_ceb !== 1'b1) begin errors++; $display("FAIL rmid_forced got gnt %b ceb %b exp 0/1", i_gnt, sram_ceb); end
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b0 || i_rdata !== '0 || dbg_rsp !== 2'd0) begin errors++; $display("FAIL rmid_drop got %b/%h rsp %0d", i_rvalid, i_rdata, dbg_rsp); end
    @(posedge clk); #1;
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_after got %b exp 0", i_rvalid); end
    drive(1'b1, 14'h0055, 1'b0, 1'b0, '0, 4'h0, '0);
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL rmid_regnt got %b exp 1", i_gnt); end
    drive_idle();
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h600D_CAFE) begin errors++; $display("FAIL rmid_resp got %b/%h exp 1/600dcafe", i_rvalid, i_rdata); end
  endtask

  // Random traffic against a plain model: priority rule, starvation count,
  // byte-merge memory, and one-cycle read return.
  task automatic test_random();
    int            ms;
    int            pend;
    logic          ir, dr, dwe, ei, ed;
    logic [AW-1:0] ia, da, ea;
    logic [3:0]    ds;
    logic [DW-1:0] dd, ebweb, exp;
    ms = 0; pend = 0;
    for (int n = 0; n < 400; n++) begin
      ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
      ia = pick_addr(); da = pick_addr(); ds = 4'($urandom); dd = $urandom;
      drive(ir, ia, dr, dwe, da, ds, dd);
      // response for last cycle's grant
      exp = '0;
      if (pend != 0) exp = exp_q.pop_front();
      checks++; if (i_rvalid !== (pend == 1) || d_rvalid !== (pend == 2)) begin errors++; $display("FAIL rnd_rvalid n %0d got %b%b pend %0d", n, i_rvalid, d_rvalid, pend); end
      checks++; if (i_rdata !== ((pend == 1) ? exp : '0) || d_rdata !== ((pend == 2) ? exp : '0)) begin errors++; $display("FAIL rnd_rdata n %0d got %h/%h exp %h pend %0d", n, i_rdata, d_rdata, exp, pend); end
      // this cycle's arbitration
      ei = ir && (!dr || ms == LIM);
      ed = dr && !ei;
      ea = ei ? ia : (ed ? da : '0);
      ebweb = '1;
      if (ed && dwe) for (int b = 0; b < 4; b++) if (ds[b]) ebweb[b*8 +: 8] = 8'h00;
      checks++; if (i_gnt !== ei || d_gnt !== ed) begin errors++; $display("FAIL rnd_gnt n %0d got %b%b exp %b%b", n, i_gnt, d_gnt, ei, ed); end
      checks++; if (dbg_starve_cnt !== SCW'(ms)) begin errors++; $display("FAIL rnd_starve n %0d got %0d exp %0d", n, dbg_starve_cnt, ms); end
      checks++; if (sram_ceb !== !(ei || ed) || sram_web !== !(ed && dwe) || sram_a !== ea || sram_bweb !== ebweb) begin
        errors++; $display("FAIL rnd_sram n %0d got ce %b we %b a %h bweb %h exp %b %b %h %h", n, sram_ceb, sram_web, sram_a, sram_bweb, !(ei || ed), !(ed && dwe), ea, ebweb);
      end
      // advance the model
      pend = 0;
      if (ei) begin
        exp_q.push_back(ref_mem[ia]); pend = 1;
      end else if (ed && !dwe) begin
        exp_q.push_back(ref_mem[da]); pend = 2;
      end else if (ed) begin
        for (int b = 0; b < 4; b++) if (ds[b]) ref_mem[da][b*8 +: 8] = dd[b*8 +: 8];
      end
      ms = (ir && !ei) ? ((ms < LIM) ? ms + 1 : LIM) : 0;
    end
    drive_idle();
    exp = '0;
    if (pend != 0) exp = exp_q.pop_front();
    checks++; if (i_rvalid !== (pend == 1) || d_rvalid !== (pend == 2) || (i_rdata | d_rdata) !== exp) begin
      errors++; $display("FAIL rnd_tail got %b%b %h/%h exp pend %0d %h", i_rvalid, d_rvalid, i_rdata, d_rdata, pend, exp);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < NW; k++) ref_mem[k] = init_pat(k);
    test_reset();
    test_idle();
    test_lone_fetch();
    test_write_strobe();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
